// File: rtl/if_dec_skid_if.sv
// Fetch-to-decode channel of the instruction buffer: fetch beat, hazard/flush controls and
// the decode-side head entry. Signal names carry the buffer's point of view.
interface if_dec_skid_if #(
  parameter int unsigned STALL_CNT_WIDTH = 16
);
  logic                       if_valid_i;
  logic [31:0]                if_instr_i;
  logic [31:0]                if_pc_i;
  logic                       if_ready_o;
  logic                       discard_i;
  logic                       stall_request_i;
  logic                       dec_ready_i;
  logic                       dec_valid_o;
  logic [31:0]                dec_instr_o;
  logic [31:0]                dec_pc_o;
  logic [4:0]                 dec_raddr1_o;
  logic [4:0]                 dec_raddr2_o;
  logic [STALL_CNT_WIDTH-1:0] stall_count_o;

  modport slave (
    input  if_valid_i, if_instr_i, if_pc_i, discard_i, stall_request_i, dec_ready_i,
    output if_ready_o, dec_valid_o, dec_instr_o, dec_pc_o, dec_raddr1_o, dec_raddr2_o,
           stall_count_o
  );

  modport master (
    output if_valid_i, if_instr_i, if_pc_i, discard_i, stall_request_i, dec_ready_i,
    input  if_ready_o, dec_valid_o, dec_instr_o, dec_pc_o, dec_raddr1_o, dec_raddr2_o,
           stall_count_o
  );
endinterface

// File: rtl/if_dec_skid.sv
// Two-entry fetch/decode instruction buffer (head + skid) with branch flush, qualified
// source-register extraction for the hazard unit and a saturating stall counter.
module if_dec_skid #(
  parameter int unsigned STALL_CNT_WIDTH = 16,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
  input logic          clk_i,
  input logic          rst_i,
  if_dec_skid_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                     state_q, state_d;
  logic [31:0]                head_instr_q, head_pc_q;
  logic [31:0]                skid_instr_q, skid_pc_q;
  logic                       if_ready_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

  logic        head_valid, accept, consume;
  logic        load_head, load_skid, shift_skid;
  logic [31:0] instr_out, pc_out;
  logic [4:0]  raddr1, raddr2;

  assign head_valid = (state_q != StEmpty);
  assign accept     = bus.if_valid_i & if_ready_q;
  assign consume    = head_valid & bus.dec_ready_i & ~bus.stall_request_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.discard_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !consume)      state_d = StTwo;
          else if (!accept && consume) state_d = StEmpty;
        end
        StTwo:   if (consume) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Head takes the fetch beat when it is (or is about to become) free; skid only when the
  // head is held.
  assign load_head  = ~bus.discard_i & accept &
                      ((state_q == StEmpty) | ((state_q == StOne) & consume));
  assign load_skid  = ~bus.discard_i & accept & (state_q == StOne) & ~consume;
  assign shift_skid = ~bus.discard_i & consume & (state_q == StTwo);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      if (load_head) begin
        head_instr_q <= bus.if_instr_i;
        head_pc_q    <= bus.if_pc_i;
      end else if (shift_skid) begin
        head_instr_q <= skid_instr_q;
        head_pc_q    <= skid_pc_q;
      end
      if (load_skid) begin
        skid_instr_q <= bus.if_instr_i;
        skid_pc_q    <= bus.if_pc_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) if_ready_q <= 1'b0;
    else        if_ready_q <= (state_d != StTwo);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (head_valid && bus.stall_request_i && !bus.discard_i && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Only register fields the instruction type actually reads are exposed, so unused fields
  // never raise a false hazard.
  always_comb begin
    instr_out = NOP_INSTR;
    pc_out    = '0;
    raddr1    = '0;
    raddr2    = '0;
    if (head_valid) begin
      instr_out = head_instr_q;
      pc_out    = head_pc_q;
      case (head_instr_q[6:0])
        7'b0110011, 7'b0010011, 7'b0000011,
        7'b0100011, 7'b1100011, 7'b1100111: raddr1 = head_instr_q[19:15];
        default:                            raddr1 = '0;
      endcase
      case (head_instr_q[6:0])
        7'b0110011, 7'b0100011, 7'b1100011: raddr2 = head_instr_q[24:20];
        default:                            raddr2 = '0;
      endcase
    end
  end

  assign bus.if_ready_o    = if_ready_q;
  assign bus.dec_valid_o   = head_valid;
  assign bus.dec_instr_o   = instr_out;
  assign bus.dec_pc_o      = pc_out;
  assign bus.dec_raddr1_o  = raddr1;
  assign bus.dec_raddr2_o  = raddr2;
  assign bus.stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_if_dec_skid.sv
// Directed and randomized checks of if_dec_skid against a queue-based model of the buffer.
module tb_if_dec_skid;
  localparam int unsigned W   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_dec_skid_if #(.STALL_CNT_WIDTH(W)) bus ();

  if_dec_skid #(.STALL_CNT_WIDTH(W), .NOP_INSTR(NOP)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  int          total = 0;
  int          bad   = 0;
  beat_t       mq[$];      // model buffer contents, head first
  beat_t       fq[$];      // beats fetch is offering, in order
  logic [31:0] seen_pc[$]; // PCs consumed from the DUT
  logic        m_ready;
  logic [W-1:0] m_cnt;
  logic        fetch_en;
  logic [31:0] next_pc;

  function automatic logic [4:0] exp_rs1(logic [31:0] i);
    case (i[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67: return i[19:15];
      default:                                  return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] exp_rs2(logic [31:0] i);
    case (i[6:0])
      7'h33, 7'h23, 7'h63: return i[24:20];
      default:             return 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] pick_opc(int unsigned k);
    case (k)
      0: return 7'h33;  1: return 7'h13;  2: return 7'h03;  3: return 7'h23;
      4: return 7'h63;  5: return 7'h67;  6: return 7'h37;  7: return 7'h17;
      8: return 7'h6f;  default: return 7'h73;
    endcase
  endfunction

  function automatic beat_t mk(logic [31:0] instr, logic [31:0] pc);
    beat_t b;
    b.instr = instr;
    b.pc    = pc;
    return b;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic v;
    v = (mq.size() > 0);
    chk({tag, ".valid"}, {31'd0, bus.dec_valid_o}, {31'd0, v});
    chk({tag, ".ready"}, {31'd0, bus.if_ready_o}, {31'd0, m_ready});
    chk({tag, ".cnt"}, 32'(bus.stall_count_o), 32'(m_cnt));
    chk({tag, ".instr"}, bus.dec_instr_o, v ? mq[0].instr : NOP);
    if (v) chk({tag, ".pc"}, bus.dec_pc_o, mq[0].pc);
    chk({tag, ".rs1"}, 32'(bus.dec_raddr1_o), v ? 32'(exp_rs1(mq[0].instr)) : 32'd0);
    chk({tag, ".rs2"}, 32'(bus.dec_raddr2_o), v ? 32'(exp_rs2(mq[0].instr)) : 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_cnt   = '0;
  endtask

  // Called at a falling edge: drives inputs, advances the model over one rising edge, checks.
  task automatic cycle(string tag);
    logic acc, cons, busy;
    bus.if_valid_i = fetch_en && (fq.size() > 0);
    bus.if_instr_i = (fq.size() > 0) ? fq[0].instr : 32'd0;
    bus.if_pc_i    = (fq.size() > 0) ? fq[0].pc : 32'd0;
    if (bus.dec_valid_o && bus.dec_ready_i && !bus.stall_request_i)
      seen_pc.push_back(bus.dec_pc_o);
    busy = (mq.size() > 0);
    acc  = bus.if_valid_i && m_ready;
    cons = busy && bus.dec_ready_i && !bus.stall_request_i;
    if (acc) begin
      if (!bus.discard_i) begin
        if (cons) void'(mq.pop_front());
        mq.push_back(fq[0]);
      end
      void'(fq.pop_front());
    end else if (cons && !bus.discard_i) begin
      void'(mq.pop_front());
    end
    if (bus.discard_i) mq.delete();
    else if (busy && bus.stall_request_i && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    m_ready = (mq.size() < 2);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    fq.delete();
    seen_pc.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.if_valid_i      = 1'b0;
    bus.if_instr_i      = '0;
    bus.if_pc_i         = '0;
    bus.discard_i       = 1'b0;
    bus.stall_request_i = 1'b0;
    bus.dec_ready_i     = 1'b1;
    fetch_en            = 1'b1;
    model_reset();

    // Streaming with no back-pressure, register qualification.
    do_reset();
    fq.push_back(mk(32'h0030_8133, 32'h100));
    fq.push_back(mk(32'h00A0_0093, 32'h104));
    fq.push_back(mk(32'h0000_12B7, 32'h108));
    cycle("first");
    chk("first_ready", {31'd0, bus.if_ready_o}, 32'd1);
    cycle("add");
    chk("add_pc", bus.dec_pc_o, 32'h100);
    chk("add_rs1", 32'(bus.dec_raddr1_o), 32'd1);
    chk("add_rs2", 32'(bus.dec_raddr2_o), 32'd3);
    cycle("addi");
    chk("addi_rs", {22'd0, bus.dec_raddr1_o, bus.dec_raddr2_o}, 32'd0);
    chk("addi_valid", {31'd0, bus.dec_valid_o}, 32'd1);
    cycle("lui");
    chk("lui_rs", {22'd0, bus.dec_raddr1_o, bus.dec_raddr2_o}, 32'd0);
    cycle("drain");

    // Three stalled cycles fill the skid, third beat held by fetch.
    do_reset();
    fq.push_back(mk(32'h0020_80B3, 32'h100));
    fq.push_back(mk(32'h0041_8233, 32'h104));
    fq.push_back(mk(32'h0062_8333, 32'h108));
    bus.stall_request_i = 1'b1;
    cycle("st0");
    cycle("st1");
    cycle("st2");
    chk("skid_ready", {31'd0, bus.if_ready_o}, 32'd0);
    cycle("st3");
    cycle("st4");
    chk("stall_cnt3", 32'(bus.stall_count_o), 32'd3);
    chk("held_pc", bus.if_pc_i, 32'h108);
    bus.stall_request_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle("st_drain");
    chk("st_seen_n", seen_pc.size(), 32'd3);
    if (seen_pc.size() == 3) begin
      chk("st_seq0", seen_pc[0], 32'h100);
      chk("st_seq1", seen_pc[1], 32'h104);
      chk("st_seq2", seen_pc[2], 32'h108);
    end

    // Discard while full, with fetch offering and stall asserted.
    do_reset();
    fq.push_back(mk(32'h0000_0013, 32'h200));
    fq.push_back(mk(32'h0000_0013, 32'h204));
    fq.push_back(mk(32'h0000_0013, 32'h208));
    bus.stall_request_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle("d2_fill");
    bus.discard_i = 1'b1;
    cycle("d2_flush");
    chk("d2_valid", {31'd0, bus.dec_valid_o}, 32'd0);
    chk("d2_ready", {31'd0, bus.if_ready_o}, 32'd1);
    chk("d2_cnt", 32'(bus.stall_count_o), 32'd1);
    bus.discard_i       = 1'b0;
    bus.stall_request_i = 1'b0;
    fq.delete();
    fq.push_back(mk(32'h0000_0013, 32'h300));
    seen_pc.delete();
    for (int i = 0; i < 3; i++) cycle("d2_after");
    chk("d2_seen_n", seen_pc.size(), 32'd1);
    if (seen_pc.size() == 1) chk("d2_seen0", seen_pc[0], 32'h300);

    // Discard in ONE while a beat is accepted the same cycle.
    do_reset();
    fq.push_back(mk(32'h0000_0013, 32'h400));
    fq.push_back(mk(32'h0000_0013, 32'h404));
    bus.stall_request_i = 1'b1;
    cycle("d1_a");
    cycle("d1_b");
    bus.discard_i = 1'b1;
    cycle("d1_flush");
    chk("d1_valid", {31'd0, bus.dec_valid_o}, 32'd0);
    bus.discard_i       = 1'b0;
    bus.stall_request_i = 1'b0;
    seen_pc.delete();
    cycle("d1_after0");
    cycle("d1_after1");
    chk("d1_seen_n", seen_pc.size(), 32'd0);

    // Counter saturation.
    do_reset();
    fq.push_back(mk(32'h0000_0013, 32'h500));
    bus.stall_request_i = 1'b1;
    cycle("sat_a");
    cycle("sat_b");
    for (int i = 0; i < 20; i++) cycle("sat");
    chk("sat_cnt", 32'(bus.stall_count_o), 32'd15);
    bus.stall_request_i = 1'b0;

    // Asynchronous reset between edges while full.
    do_reset();
    fq.push_back(mk(32'h0000_0013, 32'h600));
    fq.push_back(mk(32'h0000_0013, 32'h604));
    bus.stall_request_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle("ar_fill");
    chk("ar_full", {31'd0, bus.if_ready_o}, 32'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_valid", {31'd0, bus.dec_valid_o}, 32'd0);
    chk("ar_ready", {31'd0, bus.if_ready_o}, 32'd0);
    chk("ar_cnt", 32'(bus.stall_count_o), 32'd0);
    bus.stall_request_i = 1'b0;
    @(negedge clk);

    // Randomized traffic.
    do_reset();
    next_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      while (fq.size() < 2) begin
        w      = $urandom();
        w[6:0] = pick_opc($urandom_range(0, 9));
        fq.push_back(mk(w, next_pc));
        next_pc = next_pc + 32'd4;
      end
      fetch_en            = ($urandom_range(0, 3) != 0);
      bus.stall_request_i = ($urandom_range(0, 3) == 0);
      bus.dec_ready_i     = ($urandom_range(0, 3) != 0);
      bus.discard_i       = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
